// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, the core's two access ports and the memory.
// The slave view belongs to the arbiter; the master view is the surrounding
// core plus memory that drive requests and completions.
interface mem_arbiter_if;
  // instruction-fetch port
  logic        i_request;
  logic        i_we_re;
  logic [3:0]  i_mask;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic        i_valid;
  logic        i_error;
  logic [31:0] i_rdata;

  // load/store port
  logic        d_request;
  logic        d_we_re;
  logic [3:0]  d_mask;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic        d_error;
  logic [31:0] d_rdata;

  // shared memory bus
  logic        mem_request;
  logic        mem_we_re;
  logic [3:0]  mem_mask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_request, i_we_re, i_mask, i_address, i_wdata,
    input  d_request, d_we_re, d_mask, d_address, d_wdata,
    input  mem_valid, mem_rdata,
    output i_valid, i_error, i_rdata,
    output d_valid, d_error, d_rdata,
    output mem_request, mem_we_re, mem_mask, mem_address, mem_wdata
  );

  modport master (
    output i_request, i_we_re, i_mask, i_address, i_wdata,
    output d_request, d_we_re, d_mask, d_address, d_wdata,
    output mem_valid, mem_rdata,
    input  i_valid, i_error, i_rdata,
    input  d_valid, d_error, d_rdata,
    input  mem_request, mem_we_re, mem_mask, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction and data
// ports. The winner's request is latched onto the bus, held until the memory
// completes or the timeout expires, and answered with a one-cycle valid pulse.
// Every output is a register; the next-state logic computes the next value of
// each output so nothing passes combinationally from an input to an output.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  // a zero TIMEOUT disables the counter compare but still needs a 1-bit counter
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t      state, state_n;
  port_t       owner, owner_n;
  port_t       last_grant, last_grant_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        mem_request_n, mem_we_re_n;
  logic [3:0]  mem_mask_n;
  logic [31:0] mem_address_n, mem_wdata_n;
  logic        i_valid_n, d_valid_n, i_error_n, d_error_n;
  logic [31:0] i_rdata_n, d_rdata_n;
  logic        busy_n;

  logic        grant_d;
  logic        done;
  logic        done_error;
  logic [31:0] done_rdata;

  // Next-state and next-output logic: arbitration in IDLE, completion or
  // timeout detection in BUSY, and the single response cycle in RESP.
  always_comb begin
    state_n       = state;
    owner_n       = owner;
    last_grant_n  = last_grant;
    cnt_n         = cnt;
    mem_request_n = bus.mem_request;
    mem_we_re_n   = bus.mem_we_re;
    mem_mask_n    = bus.mem_mask;
    mem_address_n = bus.mem_address;
    mem_wdata_n   = bus.mem_wdata;
    i_valid_n     = 1'b0;
    d_valid_n     = 1'b0;
    i_error_n     = 1'b0;
    d_error_n     = 1'b0;
    i_rdata_n     = bus.i_rdata;
    d_rdata_n     = bus.d_rdata;
    busy_n        = busy;
    grant_d       = 1'b0;
    done          = 1'b0;
    done_error    = 1'b0;
    done_rdata    = 32'd0;

    case (state)
      IDLE: begin
        if (bus.i_request || bus.d_request) begin
          // on a conflict the port that did not win last time goes first
          grant_d       = bus.d_request && (!bus.i_request || last_grant == PORT_I);
          owner_n       = grant_d ? PORT_D : PORT_I;
          last_grant_n  = grant_d ? PORT_D : PORT_I;
          cnt_n         = '0;
          mem_we_re_n   = grant_d ? bus.d_we_re    : bus.i_we_re;
          mem_mask_n    = grant_d ? bus.d_mask     : bus.i_mask;
          mem_address_n = grant_d ? bus.d_address  : bus.i_address;
          mem_wdata_n   = grant_d ? bus.d_wdata    : bus.i_wdata;
          mem_request_n = 1'b1;
          busy_n        = 1'b1;
          state_n       = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_valid) begin
          done       = 1'b1;
          done_rdata = bus.mem_rdata;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
          done       = 1'b1;
          done_error = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n        = 1'b0;
        mem_request_n = 1'b0;
        state_n       = IDLE;
      end
    endcase

    if (done) begin
      mem_request_n = 1'b0;
      state_n       = RESP;
      if (owner == PORT_D) begin
        d_valid_n = 1'b1;
        d_error_n = done_error;
        d_rdata_n = done_rdata;
      end else begin
        i_valid_n = 1'b1;
        i_error_n = done_error;
        i_rdata_n = done_rdata;
      end
    end
  end

  // State and output registers; reset leaves the data port favoured for the
  // first conflict by recording the instruction port as the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= PORT_I;
      last_grant      <= PORT_I;
      cnt             <= '0;
      bus.mem_request <= 1'b0;
      bus.mem_we_re   <= 1'b0;
      bus.mem_mask    <= 4'd0;
      bus.mem_address <= 32'd0;
      bus.mem_wdata   <= 32'd0;
      bus.i_valid     <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.i_error     <= 1'b0;
      bus.d_error     <= 1'b0;
      bus.i_rdata     <= 32'd0;
      bus.d_rdata     <= 32'd0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      owner           <= owner_n;
      last_grant      <= last_grant_n;
      cnt             <= cnt_n;
      bus.mem_request <= mem_request_n;
      bus.mem_we_re   <= mem_we_re_n;
      bus.mem_mask    <= mem_mask_n;
      bus.mem_address <= mem_address_n;
      bus.mem_wdata   <= mem_wdata_n;
      bus.i_valid     <= i_valid_n;
      bus.d_valid     <= d_valid_n;
      bus.i_error     <= i_error_n;
      bus.d_error     <= d_error_n;
      bus.i_rdata     <= i_rdata_n;
      bus.d_rdata     <= d_rdata_n;
      busy            <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with TIMEOUT = 4. Directed sequences
// push the expected response (port, error, rdata, cycle) into a queue; a
// monitor pops and compares whenever either valid is seen.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        port_d;
    logic        error;
    logic [31:0] rdata;
    int          when;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  // free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // cycle counter used to check response latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_expect(input logic port_d, input logic error, input logic [31:0] rdata, input int when);
    resp_t e;
    e.port_d = port_d;
    e.error  = error;
    e.rdata  = rdata;
    e.when   = when;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic port_d, input logic we_re, input logic [3:0] mask,
                                input logic [31:0] address, input logic [31:0] wdata);
    if (port_d) begin
      bus.d_we_re    = we_re;
      bus.d_mask     = mask;
      bus.d_address  = address;
      bus.d_wdata    = wdata;
      bus.d_request  = 1'b1;
    end else begin
      bus.i_we_re    = we_re;
      bus.i_mask     = mask;
      bus.i_address  = address;
      bus.i_wdata    = wdata;
      bus.i_request  = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_request"}, 32'(bus.mem_request), 32'd0);
    check_output({tag, "_mem_we_re"},   32'(bus.mem_we_re),   32'd0);
    check_output({tag, "_mem_mask"},    32'(bus.mem_mask),    32'd0);
    check_output({tag, "_mem_address"}, bus.mem_address,      32'd0);
    check_output({tag, "_mem_wdata"},   bus.mem_wdata,        32'd0);
    check_output({tag, "_i_valid"},     32'(bus.i_valid),     32'd0);
    check_output({tag, "_d_valid"},     32'(bus.d_valid),     32'd0);
    check_output({tag, "_i_error"},     32'(bus.i_error),     32'd0);
    check_output({tag, "_d_error"},     32'(bus.d_error),     32'd0);
    check_output({tag, "_i_rdata"},     bus.i_rdata,          32'd0);
    check_output({tag, "_d_rdata"},     bus.d_rdata,          32'd0);
    check_output({tag, "_busy"},        32'(busy),            32'd0);
  endtask

  // Scoreboard monitor: every valid seen must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.i_valid || bus.d_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", {30'd0, bus.d_valid, bus.i_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("valid_i",     32'(bus.i_valid), 32'(!mon_e.port_d));
        check_output("valid_d",     32'(bus.d_valid), 32'(mon_e.port_d));
        check_output("owner_error", 32'(mon_e.port_d ? bus.d_error : bus.i_error), 32'(mon_e.error));
        check_output("other_error", 32'(mon_e.port_d ? bus.i_error : bus.d_error), 32'd0);
        check_output("rdata",       mon_e.port_d ? bus.d_rdata : bus.i_rdata, mon_e.rdata);
        check_output("valid_cycle", 32'(cyc), 32'(mon_e.when));
      end
    end
  end

  // Safety net so the run always ends even if the main sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int c0;
    rst           = 1'b1;
    bus.i_request = 1'b0; bus.i_we_re = 1'b0; bus.i_mask = 4'd0; bus.i_address = 32'd0; bus.i_wdata = 32'd0;
    bus.d_request = 1'b0; bus.d_we_re = 1'b0; bus.d_mask = 4'd0; bus.d_address = 32'd0; bus.d_wdata = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_rdata = 32'd0;

    @(negedge clk);
    tick();
    $display("[TB] reset state");
    check_all_zero("rst");
    rst = 1'b0;
    tick();

    $display("[TB] single read");
    c0 = cyc;
    apply_stimulus(1'b1, 1'b0, 4'hF, 32'h100, 32'd0);
    push_expect(1'b1, 1'b0, 32'hDEADBEEF, c0 + 2);
    tick();
    check_output("rd_mem_request", 32'(bus.mem_request), 32'd1);
    check_output("rd_mem_address", bus.mem_address, 32'h100);
    check_output("rd_mem_mask",    32'(bus.mem_mask), 32'hF);
    check_output("rd_busy",        32'(busy), 32'd1);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_valid = 1'b0;
    bus.d_request = 1'b0;
    check_output("rd_resp_mem_request", 32'(bus.mem_request), 32'd0);
    tick();
    check_output("rd_idle_busy", 32'(busy), 32'd0);
    tick();

    $display("[TB] conflict and fairness");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0 = cyc;
    apply_stimulus(1'b0, 1'b0, 4'hF, 32'h1000, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'hF, 32'h2000, 32'd0);
    for (int n = 0; n < 4; n++) begin
      push_expect(n % 2 == 0, 1'b0, 32'hA000_0000 + 32'(n), c0 + 4 * n + 3);
      tick();
      check_output("rr_mem_request", 32'(bus.mem_request), 32'd1);
      check_output("rr_mem_address", bus.mem_address, (n % 2 == 0) ? 32'h2000 : 32'h1000);
      tick();
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 32'hA000_0000 + 32'(n);
      tick();
      bus.mem_valid = 1'b0;
      check_output("rr_resp_busy", 32'(busy), 32'd1);
      if (n == 3) begin
        bus.i_request = 1'b0;
        bus.d_request = 1'b0;
      end
      tick();
    end

    $display("[TB] timeout");
    c0 = cyc;
    bus.mem_rdata = 32'h5A5A_5A5A;
    apply_stimulus(1'b0, 1'b0, 4'hF, 32'h40, 32'd0);
    push_expect(1'b0, 1'b1, 32'd0, c0 + 6);
    repeat (5) tick();
    check_output("to_mem_request_busy", 32'(bus.mem_request), 32'd1);
    tick();
    bus.i_request = 1'b0;
    check_output("to_mem_request_resp", 32'(bus.mem_request), 32'd0);
    tick();
    check_output("to_mem_request_after", 32'(bus.mem_request), 32'd0);
    check_output("to_busy_after", 32'(busy), 32'd0);

    $display("[TB] completion tied with timeout");
    c0 = cyc;
    apply_stimulus(1'b1, 1'b0, 4'hF, 32'h80, 32'd0);
    push_expect(1'b1, 1'b0, 32'hCAFEF00D, c0 + 6);
    repeat (5) tick();
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_valid = 1'b0;
    bus.d_request = 1'b0;
    tick();
    tick();

    $display("[TB] reset mid-transaction");
    apply_stimulus(1'b0, 1'b0, 4'hF, 32'h300, 32'd0);
    tick();
    check_output("mr_mem_address", bus.mem_address, 32'h300);
    tick();
    rst = 1'b1;
    bus.i_request = 1'b0;
    tick();
    check_all_zero("mr");
    rst = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    tick();
    check_output("mr_late_busy", 32'(busy), 32'd0);
    check_output("mr_late_mem_request", 32'(bus.mem_request), 32'd0);

    $display("[TB] write with spurious completion");
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h5555;
    tick();
    bus.mem_valid = 1'b0;
    check_output("wr_spurious_busy", 32'(busy), 32'd0);
    check_output("wr_spurious_d_rdata", bus.d_rdata, 32'd0);
    check_output("wr_spurious_mem_request", 32'(bus.mem_request), 32'd0);
    c0 = cyc;
    bus.mem_rdata = 32'h7777;
    apply_stimulus(1'b1, 1'b1, 4'h3, 32'h200, 32'h1234);
    push_expect(1'b1, 1'b0, 32'h7777, c0 + 4);
    for (int j = 1; j <= 3; j++) begin
      tick();
      check_output("wr_mem_request", 32'(bus.mem_request), 32'd1);
      check_output("wr_mem_address", bus.mem_address, 32'h200);
      check_output("wr_mem_mask",    32'(bus.mem_mask), 32'h3);
      check_output("wr_mem_wdata",   bus.mem_wdata, 32'h1234);
      check_output("wr_mem_we_re",   32'(bus.mem_we_re), 32'd1);
      if (j == 3) bus.mem_valid = 1'b1;
    end
    tick();
    bus.mem_valid = 1'b0;
    bus.d_request = 1'b0;
    tick();
    tick();

    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
